// File: rtl/bz_link_pkg.sv
// Shared types, defaults and header-field helpers for the board-to-board flit link.
package bz_link_pkg;

    localparam int FLIT_W_DEF    = 11;
    localparam int LEN_W_DEF     = 4;
    localparam int MAX_FLITS_DEF = 4;
    localparam int TIMEOUT_DEF   = 16;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        HOLD
    } state_t;

    // Flits are passed zero-extended to 32 bits; callers cast the result to the field width.
    function automatic logic [31:0] hdr_len(input logic [31:0] flit, input int len_w);
        return flit & ((32'd1 << len_w) - 32'd1);
    endfunction

    function automatic logic [31:0] hdr_tag(input logic [31:0] flit, input int len_w);
        return flit >> len_w;
    endfunction

endpackage

// File: rtl/bz_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
module bz_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/bz_link_rx.sv
// Link receiver: reassembles header + len data flits into one wide packet word.
// Latency: out_valid one cycle after the last data flit is accepted.
// Backpressure: in_ready drops while a packet is held; output holds until out_ready.
module bz_link_rx
    import bz_link_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int MAX_FLITS = MAX_FLITS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FLIT_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_FLITS*FLIT_W-1:0]   out_data,
    output logic [FLIT_W-LEN_W-1:0]       out_tag,
    output logic [LEN_W-1:0]              out_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              pkt_count,
    output logic [CNT_W-1:0]              err_len_count,
    output logic [CNT_W-1:0]              err_timeout_count
);

    localparam int TAG_W = FLIT_W - LEN_W;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FLITS);

    state_t                           state, state_nxt;
    logic [LEN_W-1:0]                 len_q, idx_q, hdr_len_v;
    logic [TAG_W-1:0]                 tag_q, hdr_tag_v;
    logic [MAX_FLITS-1:0][FLIT_W-1:0] payload_q;
    logic [TO_W-1:0]                  idle_q;
    logic                             acc, hdr_ok, last_flit, to_abort, deliver;

    assign hdr_len_v = LEN_W'(hdr_len(32'(in_data), LEN_W));
    assign hdr_tag_v = TAG_W'(hdr_tag(32'(in_data), LEN_W));

    // Ready/valid depend only on state (and reset), never on the partner's handshake input.
    assign in_ready  = !reset && (state != HOLD);
    assign out_valid = (state == HOLD);

    assign acc       = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign hdr_ok    = (hdr_len_v != '0) && (hdr_len_v <= MAX_LEN);
    assign last_flit = (idx_q == (len_q - LEN_W'(1)));
    assign to_abort  = (TIMEOUT > 0) && (state == BODY) && !acc && (idle_q == TO_LAST);

    assign out_data  = payload_q;
    assign out_tag   = tag_q;
    assign out_len   = len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (acc && hdr_ok) state_nxt = BODY;
            BODY: begin
                if (acc && last_flit) begin
                    state_nxt = HOLD;
                end else if (to_abort) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload is cleared per packet so slots beyond len read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            tag_q     <= '0;
            idx_q     <= '0;
            idle_q    <= '0;
            payload_q <= '0;
        end else if ((state == IDLE) && acc && hdr_ok) begin
            len_q     <= hdr_len_v;
            tag_q     <= hdr_tag_v;
            idx_q     <= '0;
            idle_q    <= '0;
            payload_q <= '0;
        end else if (state == BODY) begin
            if (acc) begin
                for (int k = 0; k < MAX_FLITS; k++) begin
                    if (idx_q == LEN_W'(k)) begin
                        payload_q[k] <= in_data;
                    end
                end
                idx_q  <= idx_q + LEN_W'(1);
                idle_q <= '0;
            end else if (!to_abort) begin
                idle_q <= idle_q + TO_W'(1);
            end
        end
    end

    bz_sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (deliver),
        .count (pkt_count)
    );

    bz_sat_counter #(.W(CNT_W)) u_err_len_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((state == IDLE) && acc && !hdr_ok),
        .count (err_len_count)
    );

    bz_sat_counter #(.W(CNT_W)) u_err_to_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (to_abort),
        .count (err_timeout_count)
    );

endmodule

// File: tb/tb_bz_link_rx.sv
// Directed bench for bz_link_rx: one task per scenario, inline expected values.
module tb_bz_link_rx;

    logic        clk;
    logic        reset;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [43:0] out_data;
    logic [6:0]  out_tag;
    logic [3:0]  out_len;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pkt_count;
    logic [15:0] err_len_count;
    logic [15:0] err_timeout_count;

    int n_cmp = 0;
    int n_err = 0;

    bz_link_rx #(
        .FLIT_W(11), .LEN_W(4), .MAX_FLITS(4), .TIMEOUT(16), .CNT_W(16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_tag           (out_tag),
        .out_len           (out_len),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .pkt_count         (pkt_count),
        .err_len_count     (err_len_count),
        .err_timeout_count (err_timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the flit until it is accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [10:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_wait: in_ready stayed %b, required 1 for flit %h", in_ready, d);
        end else begin
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if ({out_data, out_tag, out_len} !== 55'd0) begin n_err++; $display("FAIL rst_outputs: got %h/%h/%h want 0", out_data, out_tag, out_len); end
        n_cmp++; if ({pkt_count, err_len_count, err_timeout_count} !== 48'd0) begin n_err++; $display("FAIL rst_counters: got %h/%h/%h want 0", pkt_count, err_len_count, err_timeout_count); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        send(11'h023); send(11'h001); send(11'h007); send(11'h01F);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_tag !== 7'd2) begin n_err++; $display("FAIL basic_tag: got %h want 2", out_tag); end
        n_cmp++; if (out_len !== 4'd3) begin n_err++; $display("FAIL basic_len: got %h want 3", out_len); end
        n_cmp++; if (out_data !== {11'h000, 11'h01F, 11'h007, 11'h001}) begin n_err++; $display("FAIL basic_data: got %h want %h", out_data, {11'h000, 11'h01F, 11'h007, 11'h001}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        n_cmp++; if (pkt_count !== 16'd1) begin n_err++; $display("FAIL basic_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send(11'h023); send(11'h001); send(11'h007); send(11'h01F);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold[%0d]: valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
            n_cmp++; if (out_data !== {11'h000, 11'h01F, 11'h007, 11'h001} || out_tag !== 7'd2 || out_len !== 4'd3) begin n_err++; $display("FAIL bp_stable[%0d]: got %h/%h/%h", i, out_data, out_tag, out_len); end
            step();
        end
        n_cmp++; if (pkt_count !== 16'd0) begin n_err++; $display("FAIL bp_no_count: got %0d want 0", pkt_count); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (pkt_count !== 16'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: cnt=%0d valid=%b want 1/0", pkt_count, out_valid); end
        send(11'h011); send(11'h3FF);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 44'h3FF || out_tag !== 7'd1 || out_len !== 4'd1) begin n_err++; $display("FAIL bp_second: valid=%b data=%h tag=%h len=%h want 1/3ff/1/1", out_valid, out_data, out_tag, out_len); end
        step();
        n_cmp++; if (pkt_count !== 16'd2) begin n_err++; $display("FAIL bp_pkt_count: got %0d want 2", pkt_count); end
    endtask

    task automatic test_bad_len();
        do_reset();
        send(11'h050);
        n_cmp++; if (err_len_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL len0: err=%0d valid=%b ready=%b want 1/0/1", err_len_count, out_valid, in_ready); end
        send(11'h015);
        n_cmp++; if (err_len_count !== 16'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL len5: err=%0d valid=%b want 2/0", err_len_count, out_valid); end
        send(11'h011); send(11'h2AB);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 44'h2AB || out_tag !== 7'd1 || out_len !== 4'd1) begin n_err++; $display("FAIL len_recover: valid=%b data=%h tag=%h len=%h", out_valid, out_data, out_tag, out_len); end
        step();
        n_cmp++; if (pkt_count !== 16'd1 || err_len_count !== 16'd2) begin n_err++; $display("FAIL len_counts: pkt=%0d err=%0d want 1/2", pkt_count, err_len_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        send(11'h023); send(11'h005);
        for (int i = 1; i <= 15; i++) step();
        n_cmp++; if (err_timeout_count !== 16'd0) begin n_err++; $display("FAIL to_early: got %0d want 0 after 15 idle", err_timeout_count); end
        step();
        n_cmp++; if (err_timeout_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL to_abort: err=%0d valid=%b ready=%b want 1/0/1", err_timeout_count, out_valid, in_ready); end
        send(11'h012);
        n_cmp++; if (out_tag !== 7'd1 || out_len !== 4'd2 || err_len_count !== 16'd0) begin n_err++; $display("FAIL to_reparse: tag=%h len=%h errlen=%0d want 1/2/0", out_tag, out_len, err_len_count); end
        send(11'h00A); send(11'h00B);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== {22'd0, 11'h00B, 11'h00A}) begin n_err++; $display("FAIL to_after: valid=%b data=%h", out_valid, out_data); end
        // A flit landing in the would-be abort cycle keeps the packet alive.
        do_reset();
        send(11'h023); send(11'h005);
        for (int i = 1; i <= 15; i++) step();
        send(11'h006);
        n_cmp++; if (err_timeout_count !== 16'd0) begin n_err++; $display("FAIL to_race: got %0d want 0", err_timeout_count); end
        send(11'h007);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== {11'h000, 11'h007, 11'h006, 11'h005}) begin n_err++; $display("FAIL to_race_data: valid=%b data=%h", out_valid, out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(11'h023); send(11'h001); send(11'h002);
        reset = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_in_reset: got %b want 0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || {pkt_count, err_len_count, err_timeout_count} !== 48'd0) begin n_err++; $display("FAIL mid_reset: valid=%b counts=%0d/%0d/%0d", out_valid, pkt_count, err_len_count, err_timeout_count); end
        reset = 1'b0;
        #1;
        send(11'h023); send(11'h009); send(11'h008); send(11'h007);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== {11'h000, 11'h007, 11'h008, 11'h009} || out_tag !== 7'd2) begin n_err++; $display("FAIL mid_fresh: valid=%b data=%h tag=%h", out_valid, out_data, out_tag); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    send({7'(p + 3), 4'd4});
                    for (int k = 0; k < 4; k++) send(11'(p * 16 + k * 3 + 1));
                end
            end
            begin
                int seen;
                int last;
                logic [43:0] e;
                seen = 0;
                last = 0;
                for (int c = 0; c < 160; c++) begin
                    step();
                    if (out_valid) begin
                        for (int k = 0; k < 4; k++) e[k*11 +: 11] = 11'(seen * 16 + k * 3 + 1);
                        n_cmp++; if (out_data !== e || out_tag !== 7'(seen + 3) || out_len !== 4'd4) begin n_err++; $display("FAIL stream_pkt[%0d]: data=%h tag=%h len=%h want %h/%h/4", seen, out_data, out_tag, out_len, e, 7'(seen + 3)); end
                        if (seen > 0) begin
                            n_cmp++; if (c - last !== 6) begin n_err++; $display("FAIL stream_gap[%0d]: got %0d want 6", seen, c - last); end
                        end
                        last = c;
                        seen++;
                    end
                end
                n_cmp++; if (seen !== 20) begin n_err++; $display("FAIL stream_seen: got %0d want 20", seen); end
            end
        join
        n_cmp++; if (pkt_count !== 16'd20) begin n_err++; $display("FAIL stream_pkt_count: got %0d want 20", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_len();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
